// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input round-robin VC pick, then per-output
// round-robin input pick, gated by downstream on/off credit state. Grants are combinational.
module switch_allocator #(
    parameter int  PORT_NUM = 5,
    parameter int  VC_NUM   = 2,
    localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]              request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]  out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]              on_off_i,
    output logic [PORT_NUM-1:0]                          valid_sel_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel_o,
    output logic [PORT_NUM-1:0][PORT_W-1:0]              xb_sel_o,
    output logic [PORT_NUM-1:0]                          xb_valid_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]             xb_vc_o
);

    logic [PORT_NUM-1:0][VC_SIZE-1:0] in_ptr_q, in_ptr_d;
    logic [PORT_NUM-1:0][PORT_W-1:0]  out_ptr_q, out_ptr_d;

    logic [PORT_NUM-1:0][VC_NUM-1:0]  eligible;
    logic [PORT_NUM-1:0]              s1_valid;
    logic [PORT_NUM-1:0][VC_SIZE-1:0] s1_vc;
    logic [PORT_NUM-1:0][PORT_W-1:0]  s1_out;

    // Modular add by compare-and-subtract so non-power-of-two sizes wrap correctly.
    function automatic int wrap_add(input int base, input int off, input int modulo);
        int s;
        s = base + off;
        return (s >= modulo) ? s - modulo : s;
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_i[i][v] && (int'(out_port_i[i][v]) < PORT_NUM)
                    && (int'(downstream_vc_i[i][v]) < VC_NUM)) begin
                    eligible[i][v] = on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
                end
            end
        end
    end

    // Stage 1: first eligible VC at or after in_ptr.
    always_comb begin
        s1_valid = '0;
        s1_vc    = '0;
        s1_out   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                if (!s1_valid[i] && eligible[i][wrap_add(int'(in_ptr_q[i]), k, VC_NUM)]) begin
                    s1_valid[i] = 1'b1;
                    s1_vc[i]    = VC_SIZE'(wrap_add(int'(in_ptr_q[i]), k, VC_NUM));
                    s1_out[i]   = out_port_i[i][wrap_add(int'(in_ptr_q[i]), k, VC_NUM)];
                end
            end
        end
    end

    // Stage 2: first stage-1 winner targeting o at or after out_ptr; only granted pairs advance.
    always_comb begin
        valid_sel_o = '0;
        vc_sel_o    = '0;
        xb_sel_o    = '0;
        xb_valid_o  = '0;
        xb_vc_o     = '0;
        in_ptr_d    = in_ptr_q;
        out_ptr_d   = out_ptr_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                if (!xb_valid_o[o] && s1_valid[wrap_add(int'(out_ptr_q[o]), k, PORT_NUM)]
                    && (int'(s1_out[wrap_add(int'(out_ptr_q[o]), k, PORT_NUM)]) == o)) begin
                    xb_valid_o[o] = 1'b1;
                    xb_sel_o[o]   = PORT_W'(wrap_add(int'(out_ptr_q[o]), k, PORT_NUM));
                    out_ptr_d[o]  = PORT_W'(wrap_add(wrap_add(int'(out_ptr_q[o]), k, PORT_NUM), 1, PORT_NUM));
                end
            end
            if (xb_valid_o[o]) begin
                xb_vc_o[o]               = downstream_vc_i[xb_sel_o[o]][s1_vc[xb_sel_o[o]]];
                valid_sel_o[xb_sel_o[o]] = 1'b1;
                vc_sel_o[xb_sel_o[o]]    = s1_vc[xb_sel_o[o]];
                in_ptr_d[xb_sel_o[o]]    = VC_SIZE'(wrap_add(int'(s1_vc[xb_sel_o[o]]), 1, VC_NUM));
            end
        end
        // Grants are suppressed for the whole time reset is held.
        if (!rst) begin
            valid_sel_o = '0;
            vc_sel_o    = '0;
            xb_sel_o    = '0;
            xb_valid_o  = '0;
            xb_vc_o     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
        end else begin
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
        end
    end

endmodule
